// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte sources, with
// packet lock across multi-byte packets and a watchdog that frees stalled grants.
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int CLK_PER_BIT = 87,
   parameter int TIMEOUT_CYC = CLK_PER_BIT * 12
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [NUM_REQ-1:0]     i_req,
   input  logic [8*NUM_REQ-1:0]   i_req_byte,
   input  logic [NUM_REQ-1:0]     i_req_last,
   output logic [NUM_REQ-1:0]     o_req_ack,
   output logic [NUM_REQ-1:0]     o_grant,
   output logic                   o_tx_dv,
   output logic [7:0]             o_tx_byte,
   input  logic                   i_tx_active,
   input  logic                   i_tx_done,
   output logic                   o_busy,
   output logic                   o_timeout
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, HOLD} state_t;

   state_t             state, state_nxt;
   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   cand;
   logic [PTR_W-1:0]   win_idx;
   logic [PTR_W-1:0]   cap_idx;
   logic               win_found;
   logic [NUM_REQ-1:0] grant;
   logic [7:0]         cap_byte;
   logic               cap_last;
   logic [CNT_W-1:0]   wd_cnt;
   logic               wd_hit;
   logic               cap_en;
   logic               sel_new;
   logic               cnt_clr;
   logic               grant_clr;
   logic               expire;

   // First requester after the last winner, wrapping modulo NUM_REQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
         if (!win_found && i_req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign wd_hit  = (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign cap_idx = sel_new ? win_idx : ptr;

   always_comb begin
      state_nxt = state;
      cap_en    = 1'b0;
      sel_new   = 1'b0;
      cnt_clr   = 1'b0;
      grant_clr = 1'b0;
      expire    = 1'b0;
      case (state)
         IDLE: begin
            if (win_found && !i_tx_active) begin
               cap_en    = 1'b1;
               sel_new   = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            cnt_clr   = 1'b1;
            state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            // A completed frame takes priority over a coincident watchdog expiry.
            if (i_tx_done) begin
               if (cap_last) begin
                  grant_clr = 1'b1;
                  state_nxt = IDLE;
               end else if (i_req[ptr]) begin
                  cap_en    = 1'b1;
                  state_nxt = ISSUE;
               end else begin
                  cnt_clr   = 1'b1;
                  state_nxt = HOLD;
               end
            end else if (wd_hit) begin
               expire    = 1'b1;
               grant_clr = 1'b1;
               state_nxt = IDLE;
            end
         end
         HOLD: begin
            if (i_req[ptr] && !i_tx_active) begin
               cap_en    = 1'b1;
               state_nxt = ISSUE;
            end else if (wd_hit) begin
               expire    = 1'b1;
               grant_clr = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state  <= IDLE;
         ptr    <= PTR_W'(NUM_REQ - 1);
         grant  <= '0;
         wd_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (sel_new) begin
            ptr   <= win_idx;
            grant <= NUM_REQ'(1) << win_idx;
         end else if (grant_clr) begin
            grant <= '0;
         end
         if (cnt_clr)
            wd_cnt <= '0;
         else if (state == WAIT_DONE || state == HOLD)
            wd_cnt <= wd_cnt + 1'b1;
      end
   end

   // Captured byte only reaches the output while in ISSUE, so it needs no reset.
   always_ff @(posedge i_clk) begin
      if (cap_en) begin
         cap_byte <= i_req_byte[{cap_idx, 3'b000} +: 8];
         cap_last <= i_req_last[cap_idx];
      end
   end

   assign o_tx_dv   = (state == ISSUE);
   assign o_tx_byte = o_tx_dv ? cap_byte : 8'h00;
   assign o_req_ack = o_tx_dv ? grant : '0;
   assign o_grant   = grant;
   assign o_busy    = (state != IDLE);
   assign o_timeout = expire;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: behavioural uart_tx frame model plus
// queue-driven requesters; each scenario task checks its own expectations.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ     = 4;
   localparam int CLK_PER_BIT = 87;
   localparam int TIMEOUT_CYC = 1044;
   localparam int FRAME       = 10 * CLK_PER_BIT;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NUM_REQ-1:0]   req = '0;
   logic [8*NUM_REQ-1:0] req_byte = '0;
   logic [NUM_REQ-1:0]   req_last = '0;
   logic [NUM_REQ-1:0]   req_ack;
   logic [NUM_REQ-1:0]   grant;
   logic                 tx_dv;
   logic [7:0]           tx_byte;
   logic                 tx_active = 1'b0;
   logic                 tx_done = 1'b0;
   logic                 busy;
   logic                 timeout;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   uart_tx_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .CLK_PER_BIT(CLK_PER_BIT),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_req      (req),
      .i_req_byte (req_byte),
      .i_req_last (req_last),
      .o_req_ack  (req_ack),
      .o_grant    (grant),
      .o_tx_dv    (tx_dv),
      .o_tx_byte  (tx_byte),
      .i_tx_active(tx_active),
      .i_tx_done  (tx_done),
      .o_busy     (busy),
      .o_timeout  (timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // uart_tx stand-in: frame of FRAME cycles after each start pulse.
   int         busy_n = 0;
   bit         auto_done = 1'b1;
   int         force_done_cyc = -1;
   logic [7:0] sent[$];
   int         dv_cyc[$];
   int         done_q[$];

   initial begin : uart_model
      logic       saw;
      logic [7:0] b;
      forever begin
         @(negedge clk);
         saw = tx_dv;
         b   = tx_byte;
         @(posedge clk);
         #1;
         tx_done = 1'b0;
         if (cyc == force_done_cyc) begin
            tx_done = 1'b1;
            done_q.push_back(cyc);
         end
         if (busy_n > 0) begin
            busy_n--;
            if (busy_n == 0) begin
               tx_active = 1'b0;
               if (auto_done) begin
                  tx_done = 1'b1;
                  done_q.push_back(cyc);
               end
            end
         end else if (saw) begin
            tx_active = 1'b1;
            busy_n    = FRAME;
            sent.push_back(b);
            dv_cyc.push_back(cyc - 1);
         end
      end
   end

   // Requesters: per-source FIFO of {last, byte}, advanced on acknowledge.
   logic [8:0] rq_mem [NUM_REQ][16];
   int         rq_head [NUM_REQ];
   int         rq_tail [NUM_REQ];

   initial begin : requesters
      logic [NUM_REQ-1:0] a;
      for (int k = 0; k < NUM_REQ; k++) begin
         rq_head[k] = 0;
         rq_tail[k] = 0;
      end
      forever begin
         @(negedge clk);
         a = req_ack;
         @(posedge clk);
         #1;
         for (int k = 0; k < NUM_REQ; k++) begin
            if (a[k] && rq_head[k] != rq_tail[k]) rq_head[k]++;
            req[k]            = (rq_head[k] != rq_tail[k]);
            req_byte[8*k +: 8] = rq_mem[k][rq_head[k] % 16][7:0];
            req_last[k]       = rq_mem[k][rq_head[k] % 16][8];
         end
      end
   end

   int to_count = 0;
   int multi_ack = 0;
   int dv_while_active = 0;

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (timeout) to_count++;
         if ($countones(req_ack) > 1) multi_ack++;
         if (tx_dv && tx_active) dv_while_active++;
      end
   end

   initial begin : global_bound
      #(10 * 60000);
      $display("FAIL global_time_limit: simulation still running at cycle %0d, required finish earlier", cyc);
      $fatal(1);
   end

   task automatic push(input int k, input logic [7:0] b, input logic l);
      rq_mem[k][rq_tail[k] % 16] = {l, b};
      rq_tail[k]++;
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic wait_sent(input int n, input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (sent.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_idle(input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (!busy && !tx_active && busy_n == 0 && req == '0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_grant(input logic [NUM_REQ-1:0] g, input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (grant === g) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_timeout(input int lim, output bit ok, output int t);
      ok = 1'b0;
      t  = -1;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (timeout === 1'b1) begin
            ok = 1'b1;
            t  = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL reset_grant: got %b want 0000", grant); end
      vectors++; if (req_ack !== 4'b0000) begin miscompares++; $display("FAIL reset_ack: got %b want 0000", req_ack); end
      vectors++; if (tx_dv !== 1'b0) begin miscompares++; $display("FAIL reset_tx_dv: got %b want 0", tx_dv); end
      vectors++; if (tx_byte !== 8'h00) begin miscompares++; $display("FAIL reset_tx_byte: got %h want 00", tx_byte); end
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b want 0", timeout); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_single();
      bit ok;
      push(0, 8'hA5, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (req[0]) begin
            ok = 1'b1;
            break;
         end
      end
      vectors++; if (!ok) begin miscompares++; $display("FAIL single_req_seen: got 0 want 1"); end
      @(negedge clk);
      vectors++; if (tx_dv !== 1'b1) begin miscompares++; $display("FAIL single_dv_latency: got %b want 1", tx_dv); end
      vectors++; if (req_ack !== 4'b0001) begin miscompares++; $display("FAIL single_ack: got %b want 0001", req_ack); end
      vectors++; if (tx_byte !== 8'hA5) begin miscompares++; $display("FAIL single_byte: got %h want a5", tx_byte); end
      vectors++; if (grant !== 4'b0001) begin miscompares++; $display("FAIL single_grant: got %b want 0001", grant); end
      wait_idle(FRAME + 100, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL single_idle: got busy want idle"); end
      vectors++; if (sent.size() != 1 || sent[0] !== 8'hA5) begin miscompares++; $display("FAIL single_sent: got %0d bytes want 1 byte a5", sent.size()); end
      vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL single_grant_released: got %b want 0000", grant); end
   endtask

   task automatic test_round_robin();
      bit         ok;
      int         base;
      logic [7:0] exp_b [4];
      exp_b[0] = 8'h10; exp_b[1] = 8'h21; exp_b[2] = 8'h32; exp_b[3] = 8'h43;
      apply_reset();
      for (int round = 0; round < 2; round++) begin
         base = sent.size();
         for (int k = 0; k < NUM_REQ; k++) push(k, exp_b[k], 1'b1);
         wait_sent(base + 4, 4 * (FRAME + 20), ok);
         vectors++; if (!ok) begin miscompares++; $display("FAIL rr_round%0d_count: got %0d want %0d", round, sent.size() - base, 4); end
         wait_idle(FRAME + 100, ok);
         for (int k = 0; k < NUM_REQ; k++) begin
            vectors++;
            if (sent.size() <= base + k || sent[base + k] !== exp_b[k]) begin
               miscompares++;
               $display("FAIL rr_round%0d_order%0d: got %h want %h", round, k,
                        (sent.size() > base + k) ? sent[base + k] : 8'hxx, exp_b[k]);
            end
         end
      end
   endtask

   task automatic test_packet_lock();
      bit         ok;
      int         base;
      int         dbase;
      logic [7:0] exp_b [4];
      exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h03; exp_b[3] = 8'h77;
      base  = sent.size();
      dbase = done_q.size();
      push(2, 8'h01, 1'b0);
      push(2, 8'h02, 1'b0);
      push(2, 8'h03, 1'b1);
      wait_grant(4'b0100, 20, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL lock_grant2: got %b want 0100", grant); end
      push(1, 8'h77, 1'b1);
      wait_sent(base + 4, 4 * (FRAME + 20), ok);
      wait_idle(FRAME + 100, ok);
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (sent.size() <= base + k || sent[base + k] !== exp_b[k]) begin
            miscompares++;
            $display("FAIL lock_order%0d: got %h want %h", k,
                     (sent.size() > base + k) ? sent[base + k] : 8'hxx, exp_b[k]);
         end
      end
      for (int k = 1; k < 3; k++) begin
         vectors++;
         if (dv_cyc.size() <= base + k || done_q.size() <= dbase + k - 1 ||
             dv_cyc[base + k] != done_q[dbase + k - 1] + 1) begin
            miscompares++;
            $display("FAIL lock_b2b_latency%0d: dv cycle %0d, required done cycle + 1",
                     k, (dv_cyc.size() > base + k) ? dv_cyc[base + k] : -1);
         end
      end
   endtask

   task automatic test_hold_timeout();
      bit ok;
      int base;
      int dbase;
      int t;
      base  = sent.size();
      dbase = done_q.size();
      push(1, 8'h55, 1'b0);
      wait_grant(4'b0010, 20, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL hold_grant1: got %b want 0010", grant); end
      push(3, 8'h3C, 1'b1);
      wait_timeout(FRAME + TIMEOUT_CYC + 200, ok, t);
      vectors++; if (!ok) begin miscompares++; $display("FAIL hold_timeout_seen: got 0 want 1"); end
      vectors++;
      if (done_q.size() <= dbase || t != done_q[dbase] + TIMEOUT_CYC) begin
         miscompares++;
         $display("FAIL hold_timeout_cycle: got %0d want done cycle + %0d", t, TIMEOUT_CYC);
      end
      vectors++; if (sent.size() != base + 1) begin miscompares++; $display("FAIL hold_blocked: got %0d bytes want 1 during hold", sent.size() - base); end
      @(negedge clk);
      vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL hold_grant_cleared: got %b want 0000", grant); end
      wait_sent(base + 2, FRAME, ok);
      wait_idle(FRAME + 100, ok);
      vectors++; if (sent.size() <= base + 1 || sent[base + 1] !== 8'h3C) begin miscompares++; $display("FAIL hold_next_req3: got %0d bytes want 3c next", sent.size() - base); end
   endtask

   task automatic test_watchdog_exact();
      bit ok;
      int base;
      int t;
      int to0;
      wait_idle(FRAME + 100, ok);
      auto_done = 1'b0;
      base = sent.size();
      push(0, 8'h5A, 1'b1);
      wait_timeout(TIMEOUT_CYC + 100, ok, t);
      vectors++; if (!ok) begin miscompares++; $display("FAIL wd_timeout_seen: got 0 want 1"); end
      vectors++;
      if (dv_cyc.size() <= base || t != dv_cyc[base] + TIMEOUT_CYC) begin
         miscompares++;
         $display("FAIL wd_timeout_cycle: got %0d want issue cycle + %0d", t, TIMEOUT_CYC);
      end
      @(negedge clk);
      vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL wd_grant_cleared: got %b want 0000", grant); end
      wait_idle(FRAME + 100, ok);
      base = sent.size();
      push(0, 8'h6B, 1'b1);
      wait_sent(base + 1, 20, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL wd_second_issue: got 0 bytes want 1"); end
      if (ok) force_done_cyc = dv_cyc[base] + TIMEOUT_CYC;
      to0 = to_count;
      for (int i = 0; i < TIMEOUT_CYC + 50 && cyc <= force_done_cyc + 2; i++) @(negedge clk);
      vectors++; if (to_count != to0) begin miscompares++; $display("FAIL wd_done_wins: got %0d timeouts want 0", to_count - to0); end
      vectors++; if (busy !== 1'b0 || grant !== 4'b0000) begin miscompares++; $display("FAIL wd_done_idle: got busy=%b grant=%b want 0 0000", busy, grant); end
      auto_done      = 1'b1;
      force_done_cyc = -1;
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      int base;
      wait_idle(FRAME + 100, ok);
      base = sent.size();
      push(1, 8'h99, 1'b1);
      wait_sent(base + 1, 20, ok);
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL rstmid_grant: got %b want 0000", grant); end
      vectors++; if (tx_dv !== 1'b0 || req_ack !== 4'b0000 || timeout !== 1'b0 || tx_byte !== 8'h00) begin
         miscompares++; $display("FAIL rstmid_outputs: got dv=%b ack=%b to=%b byte=%h want all 0", tx_dv, req_ack, timeout, tx_byte);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      push(2, 8'hE2, 1'b1);
      push(0, 8'hE0, 1'b1);
      wait_sent(base + 3, 3 * (FRAME + 20), ok);
      wait_idle(FRAME + 100, ok);
      vectors++; if (sent.size() <= base + 1 || sent[base + 1] !== 8'hE0) begin miscompares++; $display("FAIL rstmid_req0_first: got %0d bytes want e0 first", sent.size() - base); end
      vectors++; if (sent.size() <= base + 2 || sent[base + 2] !== 8'hE2) begin miscompares++; $display("FAIL rstmid_req2_second: got %0d bytes want e2 second", sent.size() - base); end
   endtask

   task automatic test_invariants();
      vectors++; if (multi_ack != 0) begin miscompares++; $display("FAIL inv_single_ack: got %0d multi-ack cycles want 0", multi_ack); end
      vectors++; if (dv_while_active != 0) begin miscompares++; $display("FAIL inv_dv_active: got %0d cycles want 0", dv_while_active); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_packet_lock();
      test_hold_timeout();
      test_watchdog_exact();
      test_reset_mid_frame();
      test_invariants();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
